// File: rtl/pong_pkg.sv
// Shared types and screen defaults for the Pong ball datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pong_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam int H_RES_DEFAULT     = 640;
  localparam int V_RES_DEFAULT     = 480;
  localparam int BALL_SIZE_DEFAULT = 8;

  // Top-left coordinate that centres an object of length size on an axis of length res
  function automatic int centre_pos(input int res, input int size);
    return (res - size) / 2;
  endfunction

endpackage

// File: rtl/edge_probe.sv
// Latches the four sticky edge-collision flags around the ball from the obstacle pixel.
// Latency: a flag sets on the clk edge after its matching scan cycle; cleared on frame_tick.
// Backpressure: none; the scan is sampled every cycle and never stalled.
module edge_probe
  import pong_pkg::*;
#(
  parameter int CW        = 10,
  parameter int BALL_SIZE = BALL_SIZE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] h_cnt,
  input  logic [CW-1:0] v_cnt,
  input  logic          valid,
  input  logic          obstacle,
  input  logic [CW-1:0] ball_x,
  input  logic [CW-1:0] ball_y,
  input  logic          frame_tick,
  output logic          hit_l,
  output logic          hit_r,
  output logic          hit_t,
  output logic          hit_b
);

  // One extra bit so that the probe left of / above a ball at 0 lands at an
  // unreachable value instead of wrapping onto the far screen edge.
  localparam logic [CW:0] ONE  = (CW+1)'(1);
  localparam logic [CW:0] SIZE = (CW+1)'(BALL_SIZE);
  localparam logic [CW:0] HALF = (CW+1)'(BALL_SIZE / 2);

  logic [CW:0] hx, vy, bx, by, mid_x, mid_y;
  logic [CW:0] px_l, px_r, py_t, py_b;
  logic [3:0]  hit_q, hit_d;

  assign hx    = {1'b0, h_cnt};
  assign vy    = {1'b0, v_cnt};
  assign bx    = {1'b0, ball_x};
  assign by    = {1'b0, ball_y};
  assign mid_x = bx + HALF;
  assign mid_y = by + HALF;
  assign px_l  = bx - ONE;
  assign px_r  = bx + SIZE;
  assign py_t  = by - ONE;
  assign py_b  = by + SIZE;

  // Sticky flag update: frame_tick clears all, otherwise a matching obstacle pixel sets its flag
  always_comb begin
    hit_d = hit_q;
    if (frame_tick) begin
      hit_d = '0;
    end else if (valid && obstacle) begin
      if (hx == px_l && vy == mid_y) hit_d[0] = 1'b1;
      if (hx == px_r && vy == mid_y) hit_d[1] = 1'b1;
      if (hx == mid_x && vy == py_t) hit_d[2] = 1'b1;
      if (hx == mid_x && vy == py_b) hit_d[3] = 1'b1;
    end
  end

  // Flag register; reset discards anything latched mid-frame
  always_ff @(posedge clk) begin
    if (rst) hit_q <= '0;
    else     hit_q <= hit_d;
  end

  assign hit_l = hit_q[0];
  assign hit_r = hit_q[1];
  assign hit_t = hit_q[2];
  assign hit_b = hit_q[3];

endmodule

// File: rtl/ball_physics.sv
// Frame-synchronous Pong ball engine: reflections, speed ramp, position step and miss detection.
// Latency: position/speed/miss update on the clk edge that samples the first end-of-frame cycle.
// Backpressure: none; run=0 freezes motion while the flags still clear every frame.
module ball_physics
  import pong_pkg::*;
#(
  parameter int H_RES            = H_RES_DEFAULT,
  parameter int V_RES            = V_RES_DEFAULT,
  parameter int CW               = 10,
  parameter int BALL_SIZE        = BALL_SIZE_DEFAULT,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MISS_MARGIN      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] h_cnt,
  input  logic [CW-1:0] v_cnt,
  input  logic          valid,
  input  logic          obstacle,
  input  logic          run,
  input  logic          serve,
  input  logic          serve_dir,
  output logic [CW-1:0] ball_x,
  output logic [CW-1:0] ball_y,
  output logic          ball_active,
  output logic          miss_left,
  output logic          miss_right,
  output logic [2:0]    speed
);

  localparam int HW = $clog2(HITS_PER_SPEEDUP + 1);

  localparam logic [CW-1:0]   X_CTR     = CW'(centre_pos(H_RES, BALL_SIZE));
  localparam logic [CW-1:0]   Y_CTR     = CW'(centre_pos(V_RES, BALL_SIZE));
  localparam logic signed [CW:0] X_MAX  = (CW+1)'(H_RES - BALL_SIZE);
  localparam logic signed [CW:0] Y_MAX  = (CW+1)'(V_RES - BALL_SIZE);
  localparam logic [CW-1:0]   MISS_L    = CW'(MISS_MARGIN);
  localparam logic [CW-1:0]   MISS_R    = CW'(H_RES - BALL_SIZE - MISS_MARGIN);
  localparam logic [CW-1:0]   V_END     = CW'(V_RES);
  localparam logic [2:0]      SPD_INIT  = 3'(SPEED_INIT);
  localparam logic [2:0]      SPD_MAX   = 3'(SPEED_MAX);
  localparam logic [HW-1:0]   HITS_LAST = HW'(HITS_PER_SPEEDUP - 1);

  // One signed step along an axis, clamped to [0, maxp] so the ball never wraps
  function automatic logic [CW-1:0] step_pos(input logic [CW-1:0] pos, input logic dir,
                                             input logic [2:0] spd,
                                             input logic signed [CW:0] maxp);
    logic signed [CW:0] p_s, d_s, n_s;
    p_s = $signed({1'b0, pos});
    d_s = $signed({{(CW-2){1'b0}}, spd});
    n_s = dir ? (p_s + d_s) : (p_s - d_s);
    if (n_s < 0)         return '0;
    else if (n_s > maxp) return maxp[CW-1:0];
    else                 return n_s[CW-1:0];
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] bx_q, bx_d, by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic [2:0]    speed_q, speed_d;
  logic [HW-1:0] hits_q, hits_d;
  logic          miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic          eof_q, eof_d;
  logic          frame_tick;
  logic          hit_l, hit_r, hit_t, hit_b;

  assign eof_d      = (v_cnt == V_END) && (h_cnt == '0);
  assign frame_tick = eof_d && !eof_q;

  edge_probe #(
    .CW        (CW),
    .BALL_SIZE (BALL_SIZE)
  ) u_probe (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .obstacle   (obstacle),
    .ball_x     (bx_q),
    .ball_y     (by_q),
    .frame_tick (frame_tick),
    .hit_l      (hit_l),
    .hit_r      (hit_r),
    .hit_t      (hit_t),
    .hit_b      (hit_b)
  );

  // Next-state: serve from IDLE, and the end-of-frame reflect/ramp/step/miss sequence in PLAY
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    speed_d  = speed_q;
    hits_d   = hits_q;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bx_d = X_CTR;
        by_d = Y_CTR;
        if (serve && run) begin
          state_d = ST_PLAY;
          dx_d    = serve_dir;
          dy_d    = 1'b1;
          speed_d = SPD_INIT;
          hits_d  = '0;
        end
      end
      ST_PLAY: begin
        if (frame_tick && run) begin
          // Only the flag facing the direction of travel reverses it
          if (hit_l && !dx_q)     dx_d = 1'b1;
          else if (hit_r && dx_q) dx_d = 1'b0;
          if (hit_t && !dy_q)     dy_d = 1'b1;
          else if (hit_b && dy_q) dy_d = 1'b0;

          if (dx_d != dx_q) begin
            if (hits_q == HITS_LAST) begin
              hits_d = '0;
              if (speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
            end else begin
              hits_d = hits_q + HW'(1);
            end
          end

          bx_d = step_pos(bx_q, dx_d, speed_d, X_MAX);
          by_d = step_pos(by_q, dy_d, speed_d, Y_MAX);

          // Miss is judged on the stepped position; a paddle contact this frame cancels it
          if (!dx_d && !hit_l && bx_d <= MISS_L) miss_l_d = 1'b1;
          if (dx_d && !hit_r && bx_d >= MISS_R)  miss_r_d = 1'b1;
          if (miss_l_d || miss_r_d) begin
            state_d = ST_IDLE;
            bx_d    = X_CTR;
            by_d    = Y_CTR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, kinematics and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bx_q     <= X_CTR;
      by_q     <= Y_CTR;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      speed_q  <= SPD_INIT;
      hits_q   <= '0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      speed_q  <= speed_d;
      hits_q   <= hits_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
      eof_q    <= eof_d;
    end
  end

  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign ball_active = (state_q == ST_PLAY);
  assign miss_left   = miss_l_q;
  assign miss_right  = miss_r_q;
  assign speed       = speed_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics with a compressed scan: only probe pixels and end of frame are driven.
// Latency: checks sample outputs 1 time unit after the active edge.
// Backpressure: none.
module tb_ball_physics;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt, v_cnt;
  logic       valid, obstacle, run, serve, serve_dir;
  logic [9:0] ball_x, ball_y;
  logic       ball_active, miss_left, miss_right;
  logic [2:0] speed;

  int errs   = 0;
  int checks = 0;
  int ml0, ml1, mr0, mr1, act0;
  int any_miss;

  always #5 clk = ~clk;

  ball_physics dut (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .obstacle    (obstacle),
    .run         (run),
    .serve       (serve),
    .serve_dir   (serve_dir),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_active (ball_active),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .speed       (speed)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a single visible pixel for one clk
  task automatic pixel(input int x, input int y);
    h_cnt = 10'(x); v_cnt = 10'(y); valid = 1'b1; obstacle = 1'b1;
    tick();
    valid = 1'b0; obstacle = 1'b0; h_cnt = '0; v_cnt = '0;
  endtask

  // Light obstacle pixels right next to the ball, as a renderer surrounding it would
  task automatic lit(input bit l, input bit r, input bit t, input bit b);
    int bx, by;
    bx = int'(ball_x); by = int'(ball_y);
    if (l) pixel(bx - 1, by + 4);
    if (r) pixel(bx + 8, by + 4);
    if (t) pixel(bx + 4, by - 1);
    if (b) pixel(bx + 4, by + 8);
  endtask

  // End of frame held for 3 clks; records miss pulses on the first and second cycles
  task automatic end_frame();
    v_cnt = 10'd480; h_cnt = '0; valid = 1'b0; obstacle = 1'b0;
    tick();
    ml0 = int'(miss_left); mr0 = int'(miss_right); act0 = int'(ball_active);
    tick();
    ml1 = int'(miss_left); mr1 = int'(miss_right);
    tick();
    v_cnt = '0;
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_val({tag, "_x"}, int'(ball_x), 316);
    check_val({tag, "_y"}, int'(ball_y), 236);
    check_val({tag, "_active"}, int'(ball_active), 0);
    check_val({tag, "_speed"}, int'(speed), 1);
    check_val({tag, "_miss"}, int'(miss_left) + int'(miss_right), 0);
  endtask

  task automatic do_serve(input bit dir);
    serve = 1'b1; serve_dir = dir;
    tick();
    serve = 1'b0;
    check_val("serve_active", int'(ball_active), 1);
    check_val("serve_speed", int'(speed), 1);
  endtask

  initial begin
    rst = 1'b0; h_cnt = '0; v_cnt = '0; valid = 1'b0; obstacle = 1'b0;
    run = 1'b0; serve = 1'b0; serve_dir = 1'b0;

    do_reset("reset");

    // Serve right, three free frames
    run = 1'b1;
    do_serve(1'b1);
    check_val("serve_x_held", int'(ball_x), 316);
    for (int f = 0; f < 3; f++) end_frame();
    check_val("step3_x", int'(ball_x), 319);
    check_val("step3_y", int'(ball_y), 239);

    // Obstacle column at x=400, sampled on the ball's mid row
    for (int k = 0; k <= 73; k++) begin
      pixel(400, 243 + k);
      if (k == 72) check_val("col_r_early", int'(dut.u_probe.hit_r), 0);
      if (k == 73) check_val("col_r_latch", int'(dut.u_probe.hit_r), 1);
      end_frame();
    end
    check_val("refl_x", int'(ball_x), 391);
    check_val("refl_y", int'(ball_y), 313);
    check_val("refl_flag_clr", int'(dut.u_probe.hit_r), 0);

    // Forced X reflection every frame; one hit already counted
    for (int f = 0; f < 2; f++) begin lit(1, 1, 0, 0); end_frame(); end
    check_val("ramp_3hits", int'(speed), 1);
    lit(1, 1, 0, 0); end_frame();
    check_val("ramp_4hits", int'(speed), 2);
    for (int f = 0; f < 4; f++) begin lit(1, 1, 0, 0); end_frame(); end
    check_val("ramp_8hits", int'(speed), 3);
    for (int f = 0; f < 4; f++) begin lit(1, 1, 0, 0); end_frame(); end
    check_val("ramp_12hits", int'(speed), 4);
    for (int f = 0; f < 4; f++) begin lit(1, 1, 0, 0); end_frame(); end
    check_val("ramp_16hits", int'(speed), 4);

    // Reset mid-frame discards a latched flag
    lit(0, 1, 0, 0);
    check_val("pre_rst_flag", int'(dut.u_probe.hit_r), 1);
    do_reset("midrst");
    check_val("midrst_flag", int'(dut.u_probe.hit_r), 0);

    // Serve left with nothing to hit: x reaches 5 after 311 frames, Y clamps at 472
    run = 1'b1;
    do_serve(1'b0);
    any_miss = 0;
    for (int f = 0; f < 311; f++) begin
      end_frame();
      any_miss += ml0 + mr0;
    end
    check_val("pre_miss_none", any_miss, 0);
    check_val("pre_miss_x", int'(ball_x), 5);
    check_val("clamp_y", int'(ball_y), 472);
    end_frame();
    check_val("miss_l_pulse", ml0, 1);
    check_val("miss_l_width", ml1, 0);
    check_val("miss_r_quiet", mr0, 0);
    check_val("miss_active", act0, 0);
    check_val("miss_x", int'(ball_x), 316);
    check_val("miss_y", int'(ball_y), 236);

    // T and B in the same frame with dy=+: dy flips once
    do_serve(1'b1);
    lit(0, 0, 1, 1);
    end_frame();
    check_val("tb_x", int'(ball_x), 317);
    check_val("tb_y", int'(ball_y), 235);

    // Pause for 5 frames with obstacles present; last frame leaves an R flag that must clear
    run = 1'b0;
    for (int f = 0; f < 4; f++) begin lit(1, 1, 1, 1); end_frame(); end
    lit(0, 1, 0, 0);
    end_frame();
    check_val("pause_x", int'(ball_x), 317);
    check_val("pause_y", int'(ball_y), 235);
    check_val("pause_active", int'(ball_active), 1);
    run = 1'b1;
    end_frame();
    check_val("resume_x", int'(ball_x), 318);
    check_val("resume_y", int'(ball_y), 234);

    // Serve during PLAY is ignored
    serve = 1'b1; serve_dir = 1'b0;
    tick();
    serve = 1'b0;
    end_frame();
    check_val("ign_serve_x", int'(ball_x), 319);
    check_val("ign_serve_y", int'(ball_y), 233);
    check_val("ign_serve_active", int'(ball_active), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ball_physics.md
# ball_physics

Frame-synchronous ball engine for the Pong datapath with parametrised screen size, ball size and speed ramp. Each visible frame it samples four edge probes against the renderer's `obstacle` pixel (border and paddles), latches collisions, and at end of frame applies reflections, speed-up and the position step. It also reports misses to the game controller. It sits between `vga_controller`/`pixel_gen` (scan counters, obstacle pixel) and `Game` (serve, run, miss events).

## Interface
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height; end of frame is detected at `v_cnt==V_RES`.
- `CW`, 10: coordinate width.
- `BALL_SIZE`, 8: ball edge length in pixels; must be even.
- `SPEED_INIT`, 1: pixels per frame after serve.
- `SPEED_MAX`, 4: saturation speed.
- `HITS_PER_SPEEDUP`, 4: number of X reflections per speed increment.
- `MISS_MARGIN`, 4: X distance from a side edge that counts as a miss.
- `clk` in 1: system clock. The scan counters advance once every 4 `clk` cycles.
- `rst` in 1: synchronous, active-high reset.
- `h_cnt`, `v_cnt` in CW: scan position.
- `valid` in 1: the scan is in the visible area.
- `obstacle` in 1: the current pixel belongs to a bouncing object.
- `run` in 1: game is in the playing state. Low means paused.
- `serve` in 1: one-cycle pulse that launches the ball.
- `serve_dir` in 1: launch X direction, 0 = left, 1 = right.
- `ball_x`, `ball_y` out CW: top-left corner of the ball.
- `ball_active` out 1: engine is in PLAY.
- `miss_left`, `miss_right` out 1: one-cycle miss pulses.
- `speed` out 3: current pixels per frame.

## Operation
- **States:** IDLE and PLAY.
- **Reset:**
  - state is IDLE;
  - `ball_x=(H_RES-BALL_SIZE)/2` (316) and `ball_y=(V_RES-BALL_SIZE)/2` (236);
  - `speed=SPEED_INIT`, hit counter is 0, all flags are 0, miss pulses are 0, dx=+, dy=+.
- **IDLE:**
  - The ball is held at the centre.
  - `serve` together with `run` moves to PLAY: dx=`serve_dir`, dy=+, `speed=SPEED_INIT`, hit counter cleared.
- **Probes:** four probes, each latched when `valid & obstacle` and the scan position matches.
  - L at (`ball_x-1`, mid_y).
  - R at (`ball_x+BALL_SIZE`, mid_y).
  - T at (mid_x, `ball_y-1`).
  - B at (mid_x, `ball_y+BALL_SIZE`).
  - mid = position + `BALL_SIZE/2`.
  - Probe coordinates are computed in CW+1 bits, so a probe at −1 never matches.
- **frame_tick:** rising edge of (`v_cnt==V_RES && h_cnt==0`), one `clk` wide.
- **On frame_tick in PLAY with `run`:**
  1. **Reflect X:** L with dx=− gives dx=+. R with dx=+ gives dx=−. Only the flag facing the direction of travel acts, so L and R together reverse once.
  2. **Reflect Y:** same rule for T/B against dy.
  3. **Speed ramp:** each X reflection increments the hit counter. When it reaches `HITS_PER_SPEEDUP` it wraps to 0 and `speed` increments, saturating at `SPEED_MAX`.
  4. **Step:** position += ±`speed` in signed CW+1 arithmetic. X is clamped to [0, H_RES−BALL_SIZE] and Y to [0, V_RES−BALL_SIZE]; nothing wraps around.
  5. **Miss:**
     - The check uses the new position.
     - `ball_x<=MISS_MARGIN` with dx=− and no L flag gives `miss_left`.
     - `ball_x>=H_RES−BALL_SIZE−MISS_MARGIN` with dx=+ and no R flag gives `miss_right`.
     - A miss sends the engine to IDLE and recentres the ball.
  6. All four flags are cleared.
- **Pause (`run`=0 in PLAY):** position, velocity and speed hold. frame_tick still clears the flags.
- **Ignored inputs:** `serve` in PLAY is ignored.
- **Reset mid-frame:** forces reset values on the next edge and discards latched flags.

## Timing
- Flags are set on the `clk` edge after the matching scan cycle and stay sticky until frame_tick.
- `ball_x`/`ball_y`/`speed` update on the edge following the frame_tick cycle. That is 1 `clk` of latency from the end-of-frame condition being seen.
- `miss_*` assert on that same edge for exactly 1 cycle, together with `ball_active` falling.
- Serve to `ball_active`=1 takes 1 cycle. The first motion happens at the next frame_tick.
- A collision latched during frame N acts at the end of frame N; the ball drawn in frame N+1 reflects it.

## Structure
- The `pong_pkg` package holds:
  - the state enum (IDLE, PLAY);
  - screen defaults `H_RES`/`V_RES`;
  - the constant `BALL_SIZE_DEFAULT`.
- Sub-module `edge_probe`: computes the four probe coordinates, latches the sticky flags, and clears them on frame_tick.
- `ball_physics` owns the state machine, velocity, speed ramp, step/clamp and miss logic.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `ball_x`=316, `ball_y`=236, `ball_active`=0, `speed`=1, no miss pulses.
- **Serve and step:** serve with `serve_dir`=1, `run`=1, no obstacles, 3 frames → `ball_x`=319, `ball_y`=239.
- **Right reflection:**
  - Obstacle column at x=400, ball moving right.
  - Expected: R flag latched during the frame in which `ball_x+8==400`.
  - At that frame's end dx flips and `ball_x` decreases by 1.
- **Speed ramp:** 4 successive X reflections → `speed` goes 1→2. Twelve more → `speed` saturates at 4.
- **Miss:**
  - Serve left with no paddle and run until `ball_x<=4`.
  - Expected: `miss_left`=1 for exactly 1 cycle, `ball_active`=0, ball back at (316, 236).
- **Simultaneous events and pause:**
  - T and B flags in the same frame with dy=+ → dy flips once.
  - `run`=0 for 5 frames → position unchanged.
  - `serve` pulsed during PLAY → ignored.
